instr_dispatch_fsm: RTL and testbench

- Instruction sequencer that fetches 16-bit instruction words from instruction memory.
- Decodes each word and launches the ALU controller or the register-move controller through a start/done handshake.
- Is the initiator side of the handshake the ALU controller responds to: drives start, opCode, Ri and Rj, then waits for done.
- Sits between instruction memory and the per-operation controllers; owns the program counter.

---
 rtl/instr_dispatch_fsm_pkg.sv | 46 ++++
 rtl/instr_dispatch_fsm_timeout_ctr.sv | 38 +++
 rtl/instr_dispatch_fsm.sv | 160 ++++++++++++++++
 tb/tb_instr_dispatch_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_dispatch_fsm_pkg.sv
// Shared constants and types for the instruction dispatcher and its helpers.
package cpu_ctrl_pkg;

  // Opcode map
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_MOVE   = 4'h8;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // Register index map
  localparam logic [5:0] REG_R0 = 6'd0;
  localparam logic [5:0] REG_R1 = 6'd1;
  localparam logic [5:0] REG_R2 = 6'd2;
  localparam logic [5:0] REG_R3 = 6'd3;
  localparam logic [5:0] REG_P0 = 6'd4;
  localparam logic [5:0] REG_P1 = 6'd5;

  // Error causes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BADREG  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WAIT_MEM  = 4'd2,
    ST_DECODE    = 4'd3,
    ST_ISSUE     = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_NEXT      = 4'd6,
    ST_HALTED    = 4'd7,
    ST_ERROR     = 4'd8
  } disp_state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  // Ri may address R0..P0, Rj may address R0..P1
  function automatic logic regs_ok(input logic [5:0] ri, input logic [5:0] rj);
    return (ri <= REG_P0) && (rj <= REG_P1);
  endfunction

endpackage

// File: rtl/instr_dispatch_fsm_timeout_ctr.sv
// Cycle counter bounding the wait for a controller's done.
module dispatch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear loads 1 so the start-pulse cycle is part of the budget; expired
  // flags the cycle at whose edge the count reaches TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CW'(1);
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_dispatch_fsm.sv
// Fetch/decode/dispatch sequencer driving the ALU and move controllers.
module instr_dispatch_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            err_clr,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     imem_data,
  output logic [3:0]      opCode,
  output logic [5:0]      Ri,
  output logic [5:0]      Rj,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            mov_start,
  input  logic            mov_done,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output logic [1:0]      err_code
);

  disp_state_e     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            sstep_q, sstep_d;
  logic            ctr_clear, ctr_en, ctr_expired;
  logic            op_is_alu, unit_done;

  assign opCode    = ir_q[15:12];
  assign Ri        = ir_q[11:6];
  assign Rj        = ir_q[5:0];
  assign op_is_alu = is_alu_op(opCode);
  assign unit_done = op_is_alu ? alu_done : mov_done;

  dispatch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (ctr_clear),
    .enable_i  (ctr_en),
    .expired_o (ctr_expired)
  );

  // Next-state, register updates and strobes
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    err_code_d = err_code_q;
    sstep_d    = sstep_q;
    imem_rd    = 1'b0;
    alu_start  = 1'b0;
    mov_start  = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d = ST_FETCH;
          sstep_d = step;
        end
      end
      ST_FETCH: begin
        imem_rd = 1'b1;
        state_d = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        ir_d    = imem_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (opCode == HALT_OP) begin
          state_d = ST_HALTED;
        end else if (opCode == OP_NOP) begin
          state_d = ST_NEXT;
        end else if (op_is_alu || (opCode == OP_MOVE)) begin
          if (regs_ok(Ri, Rj)) begin
            state_d = ST_ISSUE;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_BADREG;
          end
        end else begin
          state_d    = ST_ERROR;
          err_code_d = ERR_ILLEGAL;
        end
      end
      ST_ISSUE: begin
        alu_start = op_is_alu;
        mov_start = !op_is_alu;
        ctr_clear = 1'b1;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        ctr_en = 1'b1;
        if (unit_done) begin
          state_d = ST_NEXT;
        end else if (ctr_expired) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_NEXT: begin
        pc_d = pc_q + PC_W'(1);
        if (run && !sstep_q) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
          sstep_d = 1'b0;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_ERROR: begin
        if (err_clr) begin
          state_d    = ST_IDLE;
          err_code_d = ERR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      err_code_q <= '0;
      sstep_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      err_code_q <= err_code_d;
      sstep_q    <= sstep_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign err_code  = err_code_q;
  assign halted    = (state_q == ST_HALTED);
  assign err       = (state_q == ST_ERROR);
  assign busy      = !((state_q == ST_IDLE) || (state_q == ST_HALTED) || (state_q == ST_ERROR));

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Self-checking bench for instr_dispatch_fsm.
module tb_instr_dispatch_fsm;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, run, step, err_clr;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [3:0]  opCode;
  logic [5:0]  Ri, Rj;
  logic        alu_start, alu_done, mov_start, mov_done;
  logic [7:0]  pc;
  logic        busy, halted, err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  instr_dispatch_fsm #(.PC_W(8), .TIMEOUT(TIMEOUT), .HALT_OP(4'hF)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .err_clr(err_clr),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .opCode(opCode), .Ri(Ri), .Rj(Rj),
    .alu_start(alu_start), .alu_done(alu_done),
    .mov_start(mov_start), .mov_done(mov_done),
    .pc(pc), .busy(busy), .halted(halted), .err(err), .err_code(err_code)
  );

  // Instruction memory and controller responders (done `lat` cycles after start, 0 = never)
  logic [15:0] mem [256];
  int unsigned alu_lat, mov_lat, alu_wait, mov_wait;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_data <= '0;
      alu_wait  <= 0;
      mov_wait  <= 0;
    end else begin
      if (imem_rd) imem_data <= mem[imem_addr];
      if (alu_start) alu_wait <= alu_lat;
      else if (alu_wait != 0) alu_wait <= alu_wait - 1;
      if (mov_start) mov_wait <= mov_lat;
      else if (mov_wait != 0) mov_wait <= mov_wait - 1;
    end
  end
  assign alu_done = (alu_wait == 1);
  assign mov_done = (mov_wait == 1);

  // Expected per-cycle outputs
  typedef struct {
    bit rd, as, ms, bz, hl, er, ops;
    bit [1:0] code;
    bit [7:0] pc;
    bit [15:0] w;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int tests = 0, fails = 0, cyc = 0;
  int rd_t[$], alu_t[$];
  int err_t = -1, starts = 0;
  bit err_prev = 0;
  logic [3:0] st_op;
  logic [5:0] st_ri, st_rj;
  bit [7:0] m_pc;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  function automatic void push_e(bit rd, bit as, bit ms, bit bz, bit hl, bit er,
                                 bit [1:0] code, bit [7:0] p, bit ops, bit [15:0] w);
    exp_t x;
    x.rd = rd; x.as = as; x.ms = ms; x.bz = bz; x.hl = hl; x.er = er;
    x.code = code; x.pc = p; x.ops = ops; x.w = w;
    exp_q.push_back(x);
  endfunction

  // Instruction-level model: each instruction contributes its phases in order.
  // Stops at halt/error (then n_tail terminal cycles) or after n_instr, ending in IDLE.
  task automatic model_exec(input int n_instr, input int n_tail);
    bit [15:0] w;
    bit [3:0] op;
    bit [5:0] ri, rj;
    bit is_alu;
    int unsigned lat;
    for (int i = 0; i < n_instr; i++) begin
      w = mem[m_pc]; op = w[15:12]; ri = w[11:6]; rj = w[5:0];
      push_e(1, 0, 0, 1, 0, 0, 0, m_pc, 0, w);
      push_e(0, 0, 0, 1, 0, 0, 0, m_pc, 0, w);
      push_e(0, 0, 0, 1, 0, 0, 0, m_pc, 1, w);
      if (op == 4'hF) begin
        repeat (n_tail) push_e(0, 0, 0, 0, 1, 0, 0, m_pc, 0, w);
        return;
      end
      if (op >= 4'h9) begin
        repeat (n_tail) push_e(0, 0, 0, 0, 0, 1, 2'd1, m_pc, 0, w);
        return;
      end
      if (op != 4'h0) begin
        if (ri > 4 || rj > 5) begin
          repeat (n_tail) push_e(0, 0, 0, 0, 0, 1, 2'd3, m_pc, 0, w);
          return;
        end
        is_alu = (op <= 4'h7);
        lat = is_alu ? alu_lat : mov_lat;
        push_e(0, is_alu, !is_alu, 1, 0, 0, 0, m_pc, 1, w);
        if (lat >= 1 && lat <= TIMEOUT - 1) begin
          repeat (lat) push_e(0, 0, 0, 1, 0, 0, 0, m_pc, 1, w);
        end else begin
          repeat (TIMEOUT - 1) push_e(0, 0, 0, 1, 0, 0, 0, m_pc, 1, w);
          repeat (n_tail) push_e(0, 0, 0, 0, 0, 1, 2'd2, m_pc, 0, w);
          return;
        end
      end
      push_e(0, 0, 0, 1, 0, 0, 0, m_pc, 0, w);
      m_pc = m_pc + 8'd1;
    end
    push_e(0, 0, 0, 0, 0, 0, 0, m_pc, 0, 16'h0000);
  endtask

  // Compare process: just after each rising edge
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_rd", imem_rd, e.rd);
      chk("alu_start", alu_start, e.as);
      chk("mov_start", mov_start, e.ms);
      chk("busy", busy, e.bz);
      chk("halted", halted, e.hl);
      chk("err", err, e.er);
      chk("err_code", err_code, e.code);
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      if (e.ops) begin
        chk("opCode", opCode, e.w[15:12]);
        chk("Ri", Ri, e.w[11:6]);
        chk("Rj", Rj, e.w[5:0]);
      end
    end
    if (imem_rd) rd_t.push_back(cyc);
    if (alu_start || mov_start) starts++;
    if (alu_start) begin
      alu_t.push_back(cyc);
      st_op = opCode; st_ri = Ri; st_rj = Rj;
    end
    if (err && !err_prev) err_t = cyc;
    err_prev = err;
  end

  task automatic do_reset();
    exp_q.delete();
    run = 0; step = 0; err_clr = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    m_pc = 0;
    rd_t.delete(); alu_t.delete();
    err_t = -1; starts = 0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_budget", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    reset = 0; run = 0; step = 0; err_clr = 0;
    alu_lat = 5; mov_lat = 3;
    clear_mem();

    // ALU instruction, done 5 cycles after start, then HALT
    mem[0] = 16'h7042; mem[1] = 16'hF000;
    do_reset();
    run = 1;
    model_exec(2, 8);
    wait_drain(200);
    chk("alu_pulse_count", alu_t.size(), 1);
    if (rd_t.size() >= 2) chk("alu_fetch_gap", rd_t[1] - rd_t[0], 10);
    else chk("alu_fetch_count", rd_t.size(), 2);
    chk("alu_start_op", st_op, 7);
    chk("alu_start_ri", st_ri, 1);
    chk("alu_start_rj", st_rj, 2);
    chk("alu_pc_after", pc, 1);

    // NOP then HALT, run stays high
    clear_mem(); mem[1] = 16'hF000;
    do_reset();
    run = 1;
    model_exec(2, 50);
    wait_drain(200);
    if (rd_t.size() >= 2) chk("nop_fetch_gap", rd_t[1] - rd_t[0], 4);
    else chk("nop_fetch_count", rd_t.size(), 2);
    chk("halt_pc", pc, 1);
    chk("halt_flag", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_no_start", starts, 0);

    // MOVE with Ri=5 -> bad register
    clear_mem(); mem[0] = 16'h8143;
    do_reset();
    run = 1;
    model_exec(1, 5);
    wait_drain(100);
    chk("badreg_err", err, 1);
    chk("badreg_code", err_code, 3);
    chk("badreg_pc", pc, 0);
    chk("badreg_no_start", starts, 0);
    err_clr = 1; run = 0;
    @(negedge clk);
    err_clr = 0;
    chk("errclr_err", err, 0);
    chk("errclr_code", err_code, 0);
    chk("errclr_busy", busy, 0);

    // ALU never answers -> timeout
    clear_mem(); mem[0] = 16'h1042;
    alu_lat = 0;
    do_reset();
    run = 1;
    model_exec(1, 4);
    wait_drain(100);
    if (alu_t.size() == 1) chk("timeout_delay", err_t - alu_t[0], 16);
    else chk("timeout_start_count", alu_t.size(), 1);
    chk("timeout_code", err_code, 2);
    err_clr = 1; run = 0;
    @(negedge clk);
    err_clr = 0;

    // done on the expiry cycle wins
    clear_mem(); mem[0] = 16'h1042; mem[1] = 16'hF000;
    alu_lat = 15;
    do_reset();
    run = 1;
    model_exec(2, 4);
    wait_drain(100);
    chk("expiry_done_err", err, 0);
    chk("expiry_done_halted", halted, 1);
    chk("expiry_done_pc", pc, 1);

    // Valid MOVE handshake
    clear_mem(); mem[0] = 16'h8045; mem[1] = 16'hF000;
    do_reset();
    run = 1;
    model_exec(2, 3);
    wait_drain(100);
    chk("move_pc", pc, 1);

    // Illegal opcode
    clear_mem(); mem[0] = 16'hA000;
    do_reset();
    run = 1;
    model_exec(1, 4);
    wait_drain(100);
    chk("illegal_code", err_code, 1);

    // run drops mid-instruction: instruction completes, then IDLE
    clear_mem(); mem[0] = 16'h7042; mem[1] = 16'h7042;
    alu_lat = 5;
    do_reset();
    run = 1;
    model_exec(1, 0);
    repeat (6) @(negedge clk);
    run = 0;
    wait_drain(100);
    chk("rundrop_pc", pc, 1);
    chk("rundrop_busy", busy, 0);

    // Asynchronous reset in the middle of WAIT_DONE
    clear_mem(); mem[0] = 16'h1042;
    alu_lat = 0;
    do_reset();
    run = 1;
    model_exec(1, 0);
    repeat (6) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    exp_q.delete();
    reset = 0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_opcode", opCode, 0);
    chk("rst_ri_rj", {Ri, Rj}, 0);
    chk("rst_flags", {halted, err, err_code}, 0);
    @(posedge clk); #1;
    chk("rst_next_alu_start", alu_start, 0);
    chk("rst_next_busy", busy, 0);
    run = 0;
    @(negedge clk);
    reset = 1;

    // pc wrap: 255 NOPs under run, then a single step from 0xFF
    clear_mem();
    do_reset();
    run = 1;
    model_exec(255, 0);
    repeat (1 + 4 * 254) @(negedge clk);
    run = 0;
    wait_drain(100);
    chk("wrap_pre_pc", pc, 8'hFF);
    step = 1;
    model_exec(1, 0);
    @(negedge clk);
    step = 0;
    wait_drain(50);
    chk("wrap_pc", pc, 0);
    chk("wrap_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
